hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. Generates the write-enable and flush strobes consumed by the PC, IF/ID and ID/EX pipeline registers. It handles load-use interlocks, control-flow redirects resolved in EX, and multi-cycle multiply/divide freezes. It is the producer side of the `IDEX_Write`/`IDEX_Flush` interface and sits beside the ID-stage decoder.

## Interface
- `MD_LAT`, 4: total stall cycles for a multiply/divide in EX; legal range 2..255.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ID_rs`, `ID_rt`  in  5 each  source registers of the instruction in ID.
- `ID_uses_rt`  in  1  ID instruction reads `rt` as a source.
- `EX_MemRead`  in  1  instruction in EX is a load.
- `EX_rt`  in  5  destination of the load in EX.
- `EX_Branch_taken`  in  1  branch in EX resolved taken.
- `EX_jump`, `EX_jr`  in  1 each  jump / jump-register in EX.
- `EX_md_start`  in  1  instruction in EX is mult/div.
- `PC_Write`, `IFID_Write`, `IDEX_Write`  out  1 each  register write enables.
- `IFID_Flush`, `IDEX_Flush`  out  1 each  register control-field clears.
- `md_busy`  out  1  multiply/divide freeze active this cycle.
- `md_done`  out  1  registered one-cycle pulse in the first cycle after a freeze.

## Operation
- State: FSM {IDLE, MD}, 8-bit down-counter `cnt`, registered `md_done`.
- Strobe outputs are combinational from state and current inputs (Mealy), so a hazard acts in the cycle it is detected.
- Conditions:
  - `redirect` = `EX_Branch_taken | EX_jump | EX_jr`.
  - `lduse` = `EX_MemRead & (EX_rt!=0) & ((EX_rt==ID_rs) | (ID_uses_rt & EX_rt==ID_rt))`.
  - `md_go` = `EX_md_start & ~md_done`. Masking by `md_done` prevents re-triggering on the still-held mult/div.
- Default outputs: all Write=1, all Flush=0, `md_busy`=0.
- Priority in IDLE, highest first:
  1. `redirect`: `IFID_Flush`=1, `IDEX_Flush`=1, writes stay 1. Load-use is ignored because the ID instruction is wrong-path.
  2. `md_go`: `PC_Write`=`IFID_Write`=`IDEX_Write`=0, `md_busy`=1. Next state MD, `cnt`<=`MD_LAT`-1.
  3. `lduse`: `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1 (bubble), `IDEX_Write`=1.
- In MD: all Write=0, all Flush=0, `md_busy`=1; redirect and lduse are ignored.
  - `cnt` decrements each cycle.
  - When `cnt`==1: next state IDLE and `md_done`<=1.
  - `md_done` clears on the following edge.
- Freeze length is exactly `MD_LAT` cycles: the entry cycle plus `MD_LAT`-1 cycles in MD.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE, `cnt`=0, `md_done`=0, statistics counters=0.
  - While `rst`=0, outputs are forced: Writes=1, Flushes=0, `md_busy`=0.
- Load-use: exactly one bubble cycle. The next cycle sees the load in MEM, so `lduse` deasserts naturally.
- Redirect: one flush cycle. Both wrong-path instructions (in IF/ID and ID) are killed at the edge ending that cycle.
- Multiply/divide: stall cycles 1..`MD_LAT`, then `md_done` is high in cycle `MD_LAT`+1. All Writes return to 1 in that cycle unless a new hazard applies.
- Reset asserted mid-freeze aborts the freeze immediately; no `md_done` pulse is produced.
- `MD_LAT`=2: enter MD with `cnt`=1 and leave after one MD cycle.

## Configuration
- `HAZARD_STATS_EN` defined: adds outputs `stall_cycles` (32-bit) and `flush_count` (32-bit).
  - `stall_cycles` increments on every cycle with `PC_Write`=0.
  - `flush_count` increments on every cycle with `IFID_Flush`=1.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Load-use: `EX_MemRead`=1, `EX_rt`=5, `ID_rs`=5 for one cycle, then `EX_MemRead`=0 -> cycle 1 has `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1; cycle 2 returns to default.
- `$zero` and rt-unused cases:
  - `EX_rt`=0 matching `ID_rs`=0 -> no stall.
  - `EX_rt`=7 = `ID_rt` with `ID_uses_rt`=0 -> no stall.
- Redirect beats load-use: `EX_jump`=1 with a concurrent lduse condition -> `IFID_Flush`=`IDEX_Flush`=1 and `PC_Write`=1.
- Multiply/divide freeze: `MD_LAT`=4, `EX_md_start` held high for 6 cycles -> `md_busy`=1 and all Writes=0 for exactly cycles 1-4; `md_done`=1 in cycle 5 with no re-trigger; cycle 6 starts a fresh freeze.
- Reset mid-freeze: drive `rst`=0 in cycle 2 of the freeze -> outputs are forced immediately (Writes=1, Flushes=0, `md_busy`=0); after release, state is IDLE and no `md_done` pulse appears.
- With `HAZARD_STATS_EN`: one load-use, one redirect and one `MD_LAT`=4 freeze -> `stall_cycles`=5, `flush_count`=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard and stall controller for the 5-stage MIPS core. Produces
// the write enables and control-field flushes for the PC, IF/ID and ID/EX
// pipeline registers. It covers load-use interlocks, EX-resolved redirects
// and multi-cycle multiply/divide freezes.
//
// Handshake note: this block has no valid/ready pairs. Every strobe is a
// level that is valid for the current cycle and is consumed at the next
// rising edge of clk by the pipeline register it controls.
//
// Parameters:
//   MD_LAT           total freeze cycles for mult/div in EX (legal 2..255)
// Ports:
//   clk, rst         core clock; asynchronous active-low reset
//   ID_rs, ID_rt     source registers of the ID instruction
//   ID_uses_rt       ID instruction reads rt
//   EX_MemRead       EX instruction is a load
//   EX_rt            destination of the load in EX
//   EX_Branch_taken  EX branch resolved taken
//   EX_jump, EX_jr   jump / jump-register in EX
//   EX_md_start      EX instruction is mult/div
//   PC_Write, IFID_Write, IDEX_Write   register write enables
//   IFID_Flush, IDEX_Flush             register control-field clears
//   md_busy          freeze active this cycle
//   md_done          registered pulse in the first cycle after a freeze
//   dbg_state        current FSM state (0 = IDLE, 1 = MD)
// Optional build macro HAZARD_STATS_EN adds:
//   stall_cycles     count of cycles with PC_Write = 0 (wraps at 2^32)
//   flush_count      count of cycles with IFID_Flush = 1 (wraps at 2^32)

module hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic       EX_Branch_taken,
    input  logic       EX_jump,
    input  logic       EX_jr,
    input  logic       EX_md_start,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IDEX_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       md_busy,
    output logic       md_done,
    output logic       dbg_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        MD   = 1'b1
    } state_t;

    // The entry cycle is the first freeze cycle, so MD holds MD_LAT-1 cycles.
    localparam logic [7:0] MD_CNT_INIT = 8'(MD_LAT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       md_done_q, md_done_nxt;

    logic redirect;
    logic lduse;
    logic md_go;

    assign redirect = EX_Branch_taken | EX_jump | EX_jr;
    assign lduse    = EX_MemRead & (EX_rt != 5'd0) &
                      ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt)));
    // The mult/div stays in EX during its own freeze; md_done masks the
    // still-held start so it does not immediately re-trigger.
    assign md_go    = EX_md_start & ~md_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            md_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            md_done_q <= md_done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        md_done_nxt = 1'b0;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        md_busy     = 1'b0;

        case (state)
            IDLE: begin
                if (redirect) begin
                    // ID instruction is wrong-path, so its load-use is moot.
                    IFID_Flush = 1'b1;
                    IDEX_Flush = 1'b1;
                end else if (md_go) begin
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Write = 1'b0;
                    md_busy    = 1'b1;
                    state_nxt  = MD;
                    cnt_nxt    = MD_CNT_INIT;
                end else if (lduse) begin
                    // Hold PC and IF/ID, insert a bubble into ID/EX.
                    PC_Write   = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Flush = 1'b1;
                end
            end
            MD: begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Write = 1'b0;
                md_busy    = 1'b1;
                cnt_nxt    = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_nxt   = IDLE;
                    md_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Reset overrides the strobes immediately, not at the next edge.
        if (!rst) begin
            PC_Write   = 1'b1;
            IFID_Write = 1'b1;
            IDEX_Write = 1'b1;
            IFID_Flush = 1'b0;
            IDEX_Flush = 1'b0;
            md_busy    = 1'b0;
        end
    end

    assign md_done   = md_done_q;
    assign dbg_state = state;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!PC_Write)
                stall_cycles <= stall_cycles + 32'd1;
            if (IFID_Flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // Expected output vector packing:
  // {PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush, md_busy, md_done}
  localparam logic [6:0] E_DEF  = 7'b1110000;
  localparam logic [6:0] E_LDU  = 7'b0010100;
  localparam logic [6:0] E_RED  = 7'b1111100;
  localparam logic [6:0] E_FRZ  = 7'b0000010;
  localparam logic [6:0] E_DONE = 7'b1110001;

  logic       clk;
  logic       rst;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic       ID_uses_rt, EX_MemRead, EX_Branch_taken, EX_jump, EX_jr, EX_md_start;
  logic       PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush;
  logic       md_busy, md_done, dbg_state;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk),
    .rst(rst),
    .ID_rs(ID_rs),
    .ID_rt(ID_rt),
    .ID_uses_rt(ID_uses_rt),
    .EX_MemRead(EX_MemRead),
    .EX_rt(EX_rt),
    .EX_Branch_taken(EX_Branch_taken),
    .EX_jump(EX_jump),
    .EX_jr(EX_jr),
    .EX_md_start(EX_md_start),
    .PC_Write(PC_Write),
    .IFID_Write(IFID_Write),
    .IDEX_Write(IDEX_Write),
    .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush),
    .md_busy(md_busy),
    .md_done(md_done),
    .dbg_state(dbg_state)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         vec_id   = 0;
  logic       vec_valid = 1'b0;
  int         exp_stall = 0;
  int         exp_flush = 0;

  // ---------------- driver ----------------
  // One vector occupies one clock cycle: inputs change 1 time unit after the
  // rising edge and the expected outputs for that cycle are queued.
  task automatic drive(input logic rst_v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic memread, input logic [4:0] ex_rt,
                       input logic br, input logic jmp, input logic jr, input logic md,
                       input logic [6:0] exp_v);
    @(posedge clk);
    #1;
    rst             = rst_v;
    ID_rs           = rs;
    ID_rt           = rt;
    ID_uses_rt      = uses_rt;
    EX_MemRead      = memread;
    EX_rt           = ex_rt;
    EX_Branch_taken = br;
    EX_jump         = jmp;
    EX_jr           = jr;
    EX_md_start     = md;
    exp_q.push_back(exp_v);
    vec_valid = 1'b1;
    if (!rst_v) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!exp_v[6]) exp_stall++;
      if (exp_v[3])  exp_flush++;
    end
  endtask

  task automatic idle(input logic rst_v, input logic [6:0] exp_v);
    drive(rst_v, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_v);
  endtask

  task automatic md_cyc(input logic md, input logic jmp, input logic [6:0] exp_v);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, jmp, 1'b0, md, exp_v);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [6:0] got, want;
    if (vec_valid) begin
      got = {PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush, md_busy, md_done};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL vec %0d outputs: got %b required a queued expectation (queue empty)",
                 vec_id, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_errors++;
          $display("FAIL vec %0d outputs {pcw,ifidw,idexw,ifidf,idexf,busy,done}: got %b required %b",
                   vec_id, got, want);
        end
      end
      vec_id++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
    EX_MemRead = 1'b0; EX_rt = 5'd0;
    EX_Branch_taken = 1'b0; EX_jump = 1'b0; EX_jr = 1'b0; EX_md_start = 1'b0;

    // Reset: outputs forced to defaults even with hazards present.
    idle(1'b0, E_DEF);
    drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, E_DEF);
    idle(1'b1, E_DEF);

    // Load-use on rs: one bubble, then default when the load moves on.
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LDU);
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
    // Load-use on rt when rt is read.
    drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, E_LDU);
    // $zero never interlocks.
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
    // rt match but rt not used.
    drive(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);

    // Redirects, each beating a concurrent load-use.
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, E_RED);
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_RED);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RED);
    // Redirect beats mult/div start: no freeze follows.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_RED);
    idle(1'b1, E_DEF);

    // Freeze with start held 6 cycles: 4 frozen, done, fresh freeze.
    md_cyc(1'b1, 1'b0, E_FRZ);
    md_cyc(1'b1, 1'b0, E_FRZ);
    md_cyc(1'b1, 1'b0, E_FRZ);
    md_cyc(1'b1, 1'b0, E_FRZ);
    md_cyc(1'b1, 1'b0, E_DONE);
    md_cyc(1'b1, 1'b0, E_FRZ);
    // Second freeze continues; redirect inside MD is ignored.
    md_cyc(1'b0, 1'b1, E_FRZ);
    md_cyc(1'b0, 1'b0, E_FRZ);
    md_cyc(1'b0, 1'b0, E_FRZ);
    md_cyc(1'b0, 1'b0, E_DONE);
    idle(1'b1, E_DEF);

    // Reset in cycle 2 of a freeze: forced defaults, no done pulse after.
    md_cyc(1'b1, 1'b0, E_FRZ);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_DEF);
    idle(1'b1, E_DEF);
    idle(1'b1, E_DEF);
    idle(1'b1, E_DEF);

    // Stats scenario: one load-use, one redirect, one 4-cycle freeze.
    drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, E_LDU);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_RED);
    md_cyc(1'b1, 1'b0, E_FRZ);
    md_cyc(1'b0, 1'b0, E_FRZ);
    md_cyc(1'b0, 1'b0, E_FRZ);
    md_cyc(1'b0, 1'b0, E_FRZ);
    md_cyc(1'b0, 1'b0, E_DONE);
    idle(1'b1, E_DEF);

    // Let the monitor drain, bounded.
    @(posedge clk);
    #1;
    vec_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    // Final state after the last vector: back in IDLE.
    n_checks++;
    if (dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL final_state: got %b required 0", dbg_state);
    end

`ifdef HAZARD_STATS_EN
    // Counts accumulate from the last reset (the mid-freeze reset above).
    n_checks++;
    if (stall_cycles !== 32'(exp_stall)) begin
      n_errors++;
      $display("FAIL stall_cycles: got %0d required %0d", stall_cycles, exp_stall);
    end
    n_checks++;
    if (flush_count !== 32'(exp_flush)) begin
      n_errors++;
      $display("FAIL flush_count: got %0d required %0d", flush_count, exp_flush);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
